// File: rtl/rf_access_arbiter_if.sv
`default_nettype none
// ============================================================================
// rf_access_arbiter_if : client A/B request bundle plus regFile pin bundle
// Rev 1.0
// ============================================================================
interface rf_access_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4
);
  logic              a_req;
  logic              a_we;
  logic [ADDR_W-1:0] a_addr;
  logic [DATA_W-1:0] a_wdata;
  logic              a_gnt;
  logic              a_rvalid;
  logic [DATA_W-1:0] a_rdata;

  logic              b_req;
  logic              b_we;
  logic [ADDR_W-1:0] b_addr;
  logic [DATA_W-1:0] b_wdata;
  logic              b_gnt;
  logic              b_rvalid;
  logic [DATA_W-1:0] b_rdata;

  logic              rf_en;
  logic              rf_wr;
  logic              rf_rd;
  logic [ADDR_W-1:0] rf_sel_i;
  logic [ADDR_W-1:0] rf_sel_o;
  logic [DATA_W-1:0] rf_wdata;
  logic [DATA_W-1:0] rf_rdata;
  logic              init_done;

  modport slave (
    input  a_req, a_we, a_addr, a_wdata,
    output a_gnt, a_rvalid, a_rdata,
    input  b_req, b_we, b_addr, b_wdata,
    output b_gnt, b_rvalid, b_rdata,
    output rf_en, rf_wr, rf_rd, rf_sel_i, rf_sel_o, rf_wdata,
    input  rf_rdata,
    output init_done
  );

  modport master (
    output a_req, a_we, a_addr, a_wdata,
    input  a_gnt, a_rvalid, a_rdata,
    output b_req, b_we, b_addr, b_wdata,
    input  b_gnt, b_rvalid, b_rdata,
    input  rf_en, rf_wr, rf_rd, rf_sel_i, rf_sel_o, rf_wdata,
    output rf_rdata,
    input  init_done
  );
endinterface
`default_nettype wire

// File: rtl/rf_access_arbiter.sv
`default_nettype none
// ============================================================================
// rf_access_arbiter : clears regFile after reset, then round-robin arbitrates
//                     one read or write per cycle between clients A and B.
// Rev 1.0
// ============================================================================
module rf_access_arbiter #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 4,
  parameter int INIT_CLEAR = 1
) (
  input  wire logic         clk,
  input  wire logic         rst,
  rf_access_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_RUN  = 2'd1
  } state_t;

  localparam state_t RST_STATE = (INIT_CLEAR != 0) ? ST_INIT : ST_RUN;

  state_t            state_q;
  logic [ADDR_W-1:0] init_cnt_q;
  logic              rr_ptr_q;     // 0: A has priority, 1: B has priority
  logic              init_done_q;

  logic              rf_en_q;
  logic              rf_wr_q;
  logic              rf_rd_q;
  logic [ADDR_W-1:0] rf_sel_i_q;
  logic [ADDR_W-1:0] rf_sel_o_q;
  logic [DATA_W-1:0] rf_wdata_q;

  logic              rd_pend_q;
  logic              rd_owner_q;   // 0: A, 1: B
  logic              a_rvalid_q;
  logic              b_rvalid_q;

  logic              w_run;
  logic              w_a_gnt;
  logic              w_b_gnt;
  logic              w_op_we;
  logic [ADDR_W-1:0] w_op_addr;
  logic [DATA_W-1:0] w_op_wdata;

  always_comb begin
    w_run      = (state_q == ST_RUN) && !rst;
    w_a_gnt    = w_run && bus.a_req && (!bus.b_req || !rr_ptr_q);
    w_b_gnt    = w_run && bus.b_req && (!bus.a_req ||  rr_ptr_q);
    w_op_we    = w_b_gnt ? bus.b_we    : bus.a_we;
    w_op_addr  = w_b_gnt ? bus.b_addr  : bus.a_addr;
    w_op_wdata = w_b_gnt ? bus.b_wdata : bus.a_wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RST_STATE;
      init_cnt_q  <= '0;
      rr_ptr_q    <= 1'b0;
      init_done_q <= 1'b0;
      rf_en_q     <= 1'b0;
      rf_wr_q     <= 1'b0;
      rf_rd_q     <= 1'b0;
      rf_sel_i_q  <= '0;
      rf_sel_o_q  <= '0;
      rf_wdata_q  <= '0;
      rd_pend_q   <= 1'b0;
      rd_owner_q  <= 1'b0;
      a_rvalid_q  <= 1'b0;
      b_rvalid_q  <= 1'b0;
    end else begin
      // regFile presents Op1 one cycle after RD, so the tag lags the issue by one stage
      a_rvalid_q  <= rd_pend_q && !rd_owner_q;
      b_rvalid_q  <= rd_pend_q &&  rd_owner_q;
      init_done_q <= (state_q == ST_RUN);
      rf_en_q     <= 1'b0;
      rf_wr_q     <= 1'b0;
      rf_rd_q     <= 1'b0;
      rd_pend_q   <= 1'b0;

      case (state_q)
        ST_INIT: begin
          rf_en_q    <= 1'b1;
          rf_wr_q    <= 1'b1;
          rf_sel_i_q <= init_cnt_q;
          rf_wdata_q <= '0;
          init_cnt_q <= init_cnt_q + ADDR_W'(1);
          if (init_cnt_q == {ADDR_W{1'b1}}) begin
            state_q <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (w_a_gnt || w_b_gnt) begin
            rr_ptr_q <= w_a_gnt;
            rf_en_q  <= 1'b1;
            if (w_op_we) begin
              rf_wr_q    <= 1'b1;
              rf_sel_i_q <= w_op_addr;
              rf_wdata_q <= w_op_wdata;
            end else begin
              rf_rd_q    <= 1'b1;
              rf_sel_o_q <= w_op_addr;
              rd_pend_q  <= 1'b1;
              rd_owner_q <= w_b_gnt;
            end
          end
        end
        default: begin
          state_q <= RST_STATE;
        end
      endcase
    end
  end

  assign bus.a_gnt     = w_a_gnt;
  assign bus.b_gnt     = w_b_gnt;
  assign bus.a_rvalid  = a_rvalid_q && !rst;
  assign bus.b_rvalid  = b_rvalid_q && !rst;
  assign bus.a_rdata   = bus.rf_rdata;
  assign bus.b_rdata   = bus.rf_rdata;
  assign bus.rf_en     = rf_en_q;
  assign bus.rf_wr     = rf_wr_q;
  assign bus.rf_rd     = rf_rd_q;
  assign bus.rf_sel_i  = rf_sel_i_q;
  assign bus.rf_sel_o  = rf_sel_o_q;
  assign bus.rf_wdata  = rf_wdata_q;
  assign bus.init_done = init_done_q;

endmodule
`default_nettype wire

// File: tb/tb_rf_access_arbiter.sv
`default_nettype none
// ============================================================================
// tb_rf_access_arbiter : scoreboard bench for rf_access_arbiter
// Rev 1.0
// ============================================================================
module tb_rf_access_arbiter;

  typedef struct {
    int          cyc;
    logic        wr;
    logic [3:0]  sel;
    logic [31:0] data;
  } iss_t;

  typedef struct {
    int          cyc;
    logic        owner;
    logic [31:0] data;
  } rd_t;

  logic clk = 1'b0;
  logic rst;
  logic rst2;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  iss_t        iq[$];
  rd_t         rq[$];
  logic [31:0] shadow[16];
  logic [31:0] mem[16];
  logic [31:0] rf_rdq;

  rf_access_arbiter_if #(.DATA_W(32), .ADDR_W(4)) bus1 ();
  rf_access_arbiter_if #(.DATA_W(32), .ADDR_W(4)) bus2 ();

  rf_access_arbiter #(.DATA_W(32), .ADDR_W(4), .INIT_CLEAR(1)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  rf_access_arbiter #(.DATA_W(32), .ADDR_W(4), .INIT_CLEAR(0)) dut2 (
    .clk (clk),
    .rst (rst2),
    .bus (bus2)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural regFile behind dut1
  always @(posedge clk) begin
    if (bus1.rf_en && bus1.rf_wr) mem[bus1.rf_sel_i] <= bus1.rf_wdata;
    if (bus1.rf_en && bus1.rf_rd) rf_rdq <= mem[bus1.rf_sel_o];
  end
  assign bus1.rf_rdata = rf_rdq;
  assign bus2.rf_rdata = 32'h0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: pops expectations whenever the DUT issues to regFile or returns read data
  always @(negedge clk) begin
    iss_t e;
    rd_t  r;
    if (bus1.rf_en) begin
      if (iq.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_issue: got rf_en=1 expected no issue (cycle %0d)", cyc);
      end else begin
        e = iq.pop_front();
        check("issue_cycle", cyc, e.cyc);
        check("issue_wr", bus1.rf_wr, e.wr);
        check("issue_rd", bus1.rf_rd, !e.wr);
        if (e.wr) begin
          check("issue_sel_i", bus1.rf_sel_i, e.sel);
          check("issue_wdata", bus1.rf_wdata, e.data);
        end else begin
          check("issue_sel_o", bus1.rf_sel_o, e.sel);
        end
      end
    end
    if (bus1.a_rvalid && bus1.b_rvalid) begin
      n_checks++;
      n_fail++;
      $display("FAIL rvalid_both: got a_rvalid=1 b_rvalid=1 expected at most one (cycle %0d)", cyc);
    end else if (bus1.a_rvalid || bus1.b_rvalid) begin
      if (rq.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_rvalid: got a=%0b b=%0b expected none (cycle %0d)",
                 bus1.a_rvalid, bus1.b_rvalid, cyc);
      end else begin
        r = rq.pop_front();
        check("rvalid_cycle", cyc, r.cyc);
        check("rvalid_owner", bus1.b_rvalid, r.owner);
        check("rdata", r.owner ? bus1.b_rdata : bus1.a_rdata, r.data);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic grant(input logic own, input logic w, input logic [3:0] a, input logic [31:0] d);
    int c;
    c = cyc;
    iq.push_back('{c + 1, w, a, d});
    if (w) shadow[a] = d;
    else   rq.push_back('{c + 2, own, shadow[a]});
  endtask

  task automatic drive(input logic ar, input logic aw, input logic [3:0] aa, input logic [31:0] ad,
                       input logic br, input logic bw, input logic [3:0] ba, input logic [31:0] bd,
                       input logic ega, input logic egb);
    bus1.a_req = ar; bus1.a_we = aw; bus1.a_addr = aa; bus1.a_wdata = ad;
    bus1.b_req = br; bus1.b_we = bw; bus1.b_addr = ba; bus1.b_wdata = bd;
    @(negedge clk);
    check("a_gnt", bus1.a_gnt, ega);
    check("b_gnt", bus1.b_gnt, egb);
    if (ega)      grant(1'b0, aw, aa, ad);
    else if (egb) grant(1'b1, bw, ba, bd);
    tick();
  endtask

  task automatic idle();
    drive(0, 0, 4'd0, 32'd0, 0, 0, 4'd0, 32'd0, 0, 0);
  endtask

  // Assert reset from the current cycle; anything not yet visible is dropped
  task automatic do_reset(input int n);
    int c;
    rst = 1'b1;
    c = cyc;
    for (int i = iq.size() - 1; i >= 0; i--) if (iq[i].cyc > c) iq.delete(i);
    for (int i = rq.size() - 1; i >= 0; i--) if (rq[i].cyc >= c) rq.delete(i);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check("rst_a_gnt", bus1.a_gnt, 1'b0);
      check("rst_b_gnt", bus1.b_gnt, 1'b0);
      check("rst_a_rvalid", bus1.a_rvalid, 1'b0);
      if (i > 0) begin
        check("rst_rf_en", bus1.rf_en, 1'b0);
        check("rst_init_done", bus1.init_done, 1'b0);
      end
      tick();
    end
  endtask

  // Release reset and run the clear sweep with A requesting a read throughout
  task automatic run_init(input int stop);
    int c0;
    rst = 1'b0;
    c0 = cyc;
    for (int k = 0; k < 16; k++) iq.push_back('{c0 + 1 + k, 1'b1, 4'(k), 32'd0});
    bus1.a_req = 1'b1; bus1.a_we = 1'b0; bus1.a_addr = 4'd0; bus1.b_req = 1'b0;
    for (int k = 0; k < stop; k++) begin
      @(negedge clk);
      check("init_a_gnt", bus1.a_gnt, 1'b0);
      check("init_b_gnt", bus1.b_gnt, 1'b0);
      check("init_done_low", bus1.init_done, 1'b0);
      tick();
    end
    if (stop == 16) begin
      for (int k = 0; k < 16; k++) shadow[k] = 32'd0;
      check("init_done_last_write", bus1.init_done, 1'b0);
    end
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout expected end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; rst2 = 1'b1;
    bus1.a_req = 0; bus1.a_we = 0; bus1.a_addr = 0; bus1.a_wdata = 0;
    bus1.b_req = 0; bus1.b_we = 0; bus1.b_addr = 0; bus1.b_wdata = 0;
    bus2.a_req = 0; bus2.a_we = 0; bus2.a_addr = 0; bus2.a_wdata = 0;
    bus2.b_req = 0; bus2.b_we = 0; bus2.b_addr = 0; bus2.b_wdata = 0;
    tick();
    do_reset(2);

    // Aborted sweep, then a full one
    run_init(5);
    do_reset(2);
    run_init(16);
    drive(1, 0, 4'd0, 32'd0, 0, 0, 4'd0, 32'd0, 1, 0);
    check("init_done_high", bus1.init_done, 1'b1);

    drive(1, 1, 4'd3, 32'hABCD_EFAB, 0, 0, 4'd0, 32'd0, 1, 0);
    drive(0, 0, 4'd0, 32'd0, 1, 0, 4'd3, 32'd0, 0, 1);

    // Both requesting, A's write held until granted
    drive(1, 0, 4'd3, 32'd0,         1, 0, 4'd0, 32'd0, 1, 0);
    drive(1, 1, 4'd7, 32'h1111_2222, 1, 0, 4'd0, 32'd0, 0, 1);
    drive(1, 1, 4'd7, 32'h1111_2222, 1, 0, 4'd7, 32'd0, 1, 0);
    drive(0, 0, 4'd0, 32'd0,         1, 0, 4'd7, 32'd0, 0, 1);

    // Write by B then read-after-write by A
    drive(0, 0, 4'd0, 32'd0, 1, 1, 4'd5, 32'h0123_4567, 0, 1);
    drive(1, 0, 4'd5, 32'd0, 0, 0, 4'd0, 32'd0,         1, 0);
    drive(1, 0, 4'd5, 32'd0, 0, 0, 4'd0, 32'd0,         1, 0);
    drive(1, 0, 4'd3, 32'd0, 0, 0, 4'd0, 32'd0,         1, 0);

    // Idle keeps the pointer at B
    idle();
    drive(1, 0, 4'd0, 32'd0, 1, 0, 4'd5, 32'd0, 0, 1);
    repeat (3) idle();

    // Reset with a read in flight and A still requesting
    drive(1, 0, 4'd7, 32'd0, 0, 0, 4'd0, 32'd0, 1, 0);
    do_reset(2);
    run_init(16);
    drive(1, 0, 4'd7, 32'd0, 0, 0, 4'd0, 32'd0, 1, 0);
    drive(1, 0, 4'd5, 32'd0, 0, 0, 4'd0, 32'd0, 1, 0);
    repeat (4) idle();
    check("issue_queue_empty", iq.size(), 0);
    check("read_queue_empty", rq.size(), 0);

    // Instance without the clear sweep
    bus2.a_req = 1'b1; bus2.a_we = 1'b1; bus2.a_addr = 4'd9; bus2.a_wdata = 32'h5A5A_5A5A;
    @(negedge clk);
    check("nc_rst_a_gnt", bus2.a_gnt, 1'b0);
    tick();
    rst2 = 1'b0;
    @(negedge clk);
    check("nc_init_done_release", bus2.init_done, 1'b0);
    check("nc_a_gnt", bus2.a_gnt, 1'b1);
    check("nc_no_clear_write", bus2.rf_en, 1'b0);
    tick();
    bus2.a_req = 1'b0;
    @(negedge clk);
    check("nc_init_done", bus2.init_done, 1'b1);
    check("nc_rf_en", bus2.rf_en, 1'b1);
    check("nc_rf_wr", bus2.rf_wr, 1'b1);
    check("nc_rf_sel_i", bus2.rf_sel_i, 4'd9);
    check("nc_rf_wdata", bus2.rf_wdata, 32'h5A5A_5A5A);
    tick();
    @(negedge clk);
    check("nc_rf_en_idle", bus2.rf_en, 1'b0);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
